// File: rtl/jump_execute_unit_pkg.sv
// Shared jump-control encodings and FSM state constants for the jump execute unit.
package jump_execute_unit_pkg;

   typedef logic [1:0] jump_ctrl_t;

   // Decoder produces these same encodings; 2'b11 is unused and treated as a no-op.
   localparam jump_ctrl_t JMP_NOP  = 2'b00;
   localparam jump_ctrl_t JMP_JAL  = 2'b01;
   localparam jump_ctrl_t JMP_JALR = 2'b10;

   // state   | meaning
   // IDLE    | waiting for a decoded jump op
   // HOLD    | result registered, waiting for downstream handshake
   // FLUSH   | redirect accepted, squashing younger instructions
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_HOLD  = 2'b01;
   localparam logic [1:0] ST_FLUSH = 2'b10;

endpackage

// File: rtl/jump_execute_unit_jump_target_calc.sv
// Combinational JAL/JALR target, link value and alignment check.
module jump_target_calc
   import jump_execute_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      jump_control,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [20:0]     imm,
   output logic [XLEN-1:0] target,
   output logic [XLEN-1:0] link_data,
   output logic            misalign,
   output logic            is_jump
);

   logic [XLEN-1:0] jal_sum;
   logic [XLEN-1:0] jalr_sum;

   assign jal_sum   = pc + {{(XLEN-21){imm[20]}}, imm};
   assign jalr_sum  = rs1_data + {{(XLEN-12){imm[11]}}, imm[11:0]};
   assign link_data = pc + XLEN'(4);

   // Select target by op; JALR clears bit 0 before the alignment check.
   always_comb begin
      target   = '0;
      misalign = 1'b0;
      is_jump  = 1'b0;
      case (jump_control)
         JMP_JAL: begin
            target   = jal_sum;
            misalign = jal_sum[1];
            is_jump  = 1'b1;
         end
         JMP_JALR: begin
            target   = {jalr_sum[XLEN-1:1], 1'b0};
            misalign = jalr_sum[1];
            is_jump  = 1'b1;
         end
         default: begin
            target   = '0;
            misalign = 1'b0;
            is_jump  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/jump_execute_unit.sv
// Jump execute unit: registers resolved jump results, handshakes them to fetch,
// and holds a flush window after each accepted redirect.
module jump_execute_unit
   import jump_execute_unit_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        jump_control,
   input  logic [4:0]        rd,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [20:0]       imm,
   input  logic [XLEN-1:0]   pc,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              redirect_en,
   output logic              wb_en,
   output logic [4:0]        wb_rd,
   output logic [XLEN-1:0]   link_data,
   output logic              misalign,
   output logic              flush,
   output logic [CNT_W-1:0]  jump_count
);

   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

   logic [1:0]       state_q, state_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;
   logic             res_valid_q, res_valid_d;
   logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
   logic             redirect_en_q, redirect_en_d;
   logic             wb_en_q, wb_en_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]  link_q, link_d;
   logic             misalign_q, misalign_d;
   logic [CNT_W-1:0] jcnt_q, jcnt_d;

   logic [XLEN-1:0]  calc_target;
   logic [XLEN-1:0]  calc_link;
   logic             calc_misalign;
   logic             calc_is_jump;
   logic             accept;
   logic             handshake;

   jump_target_calc #(.XLEN(XLEN)) u_calc (
      .jump_control (jump_control),
      .pc           (pc),
      .rs1_data     (rs1_data),
      .imm          (imm),
      .target       (calc_target),
      .link_data    (calc_link),
      .misalign     (calc_misalign),
      .is_jump      (calc_is_jump)
   );

   assign in_ready  = (state_q == ST_IDLE) && (!res_valid_q || res_ready);
   assign accept    = in_valid && in_ready;
   assign handshake = res_valid_q && res_ready;

   // Next-state and result capture; no-ops are consumed without producing a result.
   always_comb begin
      state_d       = state_q;
      fcnt_d        = fcnt_q;
      res_valid_d   = res_valid_q;
      redirect_pc_d = redirect_pc_q;
      redirect_en_d = redirect_en_q;
      wb_en_d       = wb_en_q;
      wb_rd_d       = wb_rd_q;
      link_d        = link_q;
      misalign_d    = misalign_q;
      jcnt_d        = jcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && calc_is_jump) begin
               res_valid_d   = 1'b1;
               redirect_pc_d = calc_target;
               link_d        = calc_link;
               wb_rd_d       = rd;
               misalign_d    = calc_misalign;
               redirect_en_d = !calc_misalign;
               wb_en_d       = (rd != 5'd0) && !calc_misalign;
               state_d       = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (handshake) begin
               res_valid_d   = 1'b0;
               redirect_en_d = 1'b0;
               wb_en_d       = 1'b0;
               misalign_d    = 1'b0;
               if (redirect_en_q) begin
                  jcnt_d  = jcnt_q + CNT_W'(1);
                  fcnt_d  = FC_W'(FLUSH_CYCLES);
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_FLUSH: begin
            if (fcnt_q <= FC_W'(1)) begin
               fcnt_d  = '0;
               state_d = ST_IDLE;
            end else begin
               fcnt_d = fcnt_q - FC_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         fcnt_q        <= '0;
         res_valid_q   <= 1'b0;
         redirect_pc_q <= '0;
         redirect_en_q <= 1'b0;
         wb_en_q       <= 1'b0;
         wb_rd_q       <= '0;
         link_q        <= '0;
         misalign_q    <= 1'b0;
         jcnt_q        <= '0;
      end else begin
         state_q       <= state_d;
         fcnt_q        <= fcnt_d;
         res_valid_q   <= res_valid_d;
         redirect_pc_q <= redirect_pc_d;
         redirect_en_q <= redirect_en_d;
         wb_en_q       <= wb_en_d;
         wb_rd_q       <= wb_rd_d;
         link_q        <= link_d;
         misalign_q    <= misalign_d;
         jcnt_q        <= jcnt_d;
      end
   end

   assign res_valid   = res_valid_q;
   assign redirect_pc = redirect_pc_q;
   assign redirect_en = redirect_en_q;
   assign wb_en       = wb_en_q;
   assign wb_rd       = wb_rd_q;
   assign link_data   = link_q;
   assign misalign    = misalign_q;
   assign flush       = (state_q == ST_FLUSH);
   assign jump_count  = jcnt_q;

endmodule

// File: tb/tb_jump_execute_unit.sv
// Self-checking bench for jump_execute_unit: directed table, random ops against
// an arithmetic reference model, and a reset-during-flush sequence.
module tb_jump_execute_unit;

   localparam int XLEN         = 32;
   localparam int FLUSH_CYCLES = 2;
   localparam int CNT_W        = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [1:0]        jump_control = 2'b00;
   logic [4:0]        rd = '0;
   logic [XLEN-1:0]   rs1_data = '0;
   logic [20:0]       imm = '0;
   logic [XLEN-1:0]   pc = '0;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [XLEN-1:0]   redirect_pc;
   logic              redirect_en;
   logic              wb_en;
   logic [4:0]        wb_rd;
   logic [XLEN-1:0]   link_data;
   logic              misalign;
   logic              flush;
   logic [CNT_W-1:0]  jump_count;

   jump_execute_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .jump_control (jump_control),
      .rd           (rd),
      .rs1_data     (rs1_data),
      .imm          (imm),
      .pc           (pc),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .redirect_pc  (redirect_pc),
      .redirect_en  (redirect_en),
      .wb_en        (wb_en),
      .wb_rd        (wb_rd),
      .link_data    (link_data),
      .misalign     (misalign),
      .flush        (flush),
      .jump_count   (jump_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ctl;
      logic [4:0]  rd;
      logic [31:0] rs1;
      logic [20:0] imm;
      logic [31:0] pc;
      int          stall;
      logic [31:0] tgt;
      logic [31:0] link;
      logic        mis;
      logic        wb;
   } vec_t;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_jc = '0;
   vec_t        tbl[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic modulo 2^32.
   function automatic vec_t model(input vec_t v);
      vec_t   r;
      longint off;
      longint t;
      longint m32;
      r   = v;
      m32 = 64'd4294967296;
      r.tgt = '0;
      r.mis = 1'b0;
      if (v.ctl == 2'b01) begin
         off = v.imm;
         if (v.imm[20]) off = off - 64'd2097152;
         t = (longint'(v.pc) + off + m32) % m32;
         r.tgt = t[31:0];
         r.mis = ((t / 2) % 2) != 0;
      end else if (v.ctl == 2'b10) begin
         off = v.imm[11:0];
         if (v.imm[11]) off = off - 64'd4096;
         t = (longint'(v.rs1) + off + m32) % m32;
         t = t - (t % 2);
         r.tgt = t[31:0];
         r.mis = (t % 4) != 0;
      end
      t      = (longint'(v.pc) + 4) % m32;
      r.link = t[31:0];
      r.wb   = (v.rd != 0) && !r.mis;
      return r;
   endfunction

   task automatic check_result(input string tag, input vec_t v);
      chk({tag, ".res_valid"},   32'(res_valid),   32'd1);
      chk({tag, ".redirect_pc"}, redirect_pc,      v.tgt);
      chk({tag, ".link_data"},   link_data,        v.link);
      chk({tag, ".misalign"},    32'(misalign),    32'(v.mis));
      chk({tag, ".redirect_en"}, 32'(redirect_en), 32'(!v.mis));
      chk({tag, ".wb_en"},       32'(wb_en),       32'(v.wb));
      chk({tag, ".wb_rd"},       32'(wb_rd),       32'(v.rd));
   endtask

   // Starts and ends at a negedge with the unit idle.
   task automatic run_op(input string tag, input vec_t v);
      chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
      in_valid     = 1'b1;
      jump_control = v.ctl;
      rd           = v.rd;
      rs1_data     = v.rs1;
      imm          = v.imm;
      pc           = v.pc;
      res_ready    = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      if (v.ctl == 2'b00 || v.ctl == 2'b11) begin
         chk({tag, ".nop_res_valid"}, 32'(res_valid), 32'd0);
         chk({tag, ".nop_in_ready"},  32'(in_ready),  32'd1);
         chk({tag, ".nop_jc"},        jump_count,     exp_jc);
         return;
      end
      check_result(tag, v);
      // A competing op is offered during HOLD; it must not be taken.
      in_valid     = 1'b1;
      jump_control = 2'b01;
      pc           = 32'h0000_5000;
      imm          = 21'h0;
      rd           = 5'd7;
      for (int i = 0; i < v.stall; i++) begin
         chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
         chk({tag, ".hold_flush"},    32'(flush),    32'd0);
         @(negedge clk);
         check_result({tag, ".stall"}, v);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, ".post_res_valid"}, 32'(res_valid), 32'd0);
      if (!v.mis) begin
         exp_jc = exp_jc + 1;
         for (int f = 0; f < FLUSH_CYCLES; f++) begin
            chk({tag, ".flush"},          32'(flush),    32'd1);
            chk({tag, ".flush_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, ".flush_jc"},       jump_count,    exp_jc);
            @(negedge clk);
         end
      end
      chk({tag, ".end_flush"},    32'(flush),    32'd0);
      chk({tag, ".end_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, ".end_jc"},       jump_count,    exp_jc);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      //            ctl    rd     rs1           imm         pc            stall tgt           link          mis   wb
      tbl[0] = '{2'b01, 5'd1,  32'h0,        21'h000010, 32'h0000_0100, 0, 32'h0000_0110, 32'h0000_0104, 1'b0, 1'b1};
      tbl[1] = '{2'b01, 5'd5,  32'h0,        21'h1FFFF0, 32'h0000_0100, 3, 32'h0000_00F0, 32'h0000_0104, 1'b0, 1'b1};
      tbl[2] = '{2'b10, 5'd0,  32'h0000_2001, 21'h000004, 32'h0000_0200, 0, 32'h0000_2004, 32'h0000_0204, 1'b0, 1'b0};
      tbl[3] = '{2'b01, 5'd4,  32'h0,        21'h000002, 32'h0000_0100, 1, 32'h0000_0102, 32'h0000_0104, 1'b1, 1'b0};
      tbl[4] = '{2'b00, 5'd4,  32'h0,        21'h000010, 32'h0000_0100, 0, 32'h0,         32'h0,         1'b0, 1'b0};
      tbl[5] = '{2'b11, 5'd4,  32'h0,        21'h000010, 32'h0000_0100, 0, 32'h0,         32'h0,         1'b0, 1'b0};
      tbl[6] = '{2'b01, 5'd3,  32'h0,        21'h000008, 32'hFFFF_FFFC, 0, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1};
      tbl[7] = '{2'b10, 5'd9,  32'h0000_1000, 21'h000FFE, 32'h0000_0300, 2, 32'h0000_0FFE, 32'h0000_0304, 1'b1, 1'b0};
      tbl[8] = '{2'b10, 5'd2,  32'h0000_0003, 21'h000000, 32'h0000_0400, 0, 32'h0000_0002, 32'h0000_0404, 1'b1, 1'b0};
      tbl[9] = '{2'b10, 5'd31, 32'h0000_2000, 21'h000FF8, 32'h0000_0500, 1, 32'h0000_1FF8, 32'h0000_0504, 1'b0, 1'b1};

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst.in_ready",    32'(in_ready),    32'd1);
      chk("rst.res_valid",   32'(res_valid),   32'd0);
      chk("rst.flush",       32'(flush),       32'd0);
      chk("rst.redirect_en", 32'(redirect_en), 32'd0);
      chk("rst.wb_en",       32'(wb_en),       32'd0);
      chk("rst.jump_count",  jump_count,       32'd0);

      for (int i = 0; i < 10; i++) begin
         run_op($sformatf("tbl%0d", i), tbl[i]);
      end

      for (int i = 0; i < 150; i++) begin
         v.ctl   = 2'($urandom_range(0, 3));
         v.rd    = 5'($urandom);
         v.rs1   = $urandom;
         v.pc    = $urandom & 32'hFFFF_FFFC;
         v.stall = $urandom_range(0, 2);
         if (v.ctl == 2'b10) v.imm = {9'h0, 12'($urandom)};
         else                v.imm = 21'($urandom) & 21'h1FFFFE;
         v = model(v);
         run_op($sformatf("rnd%0d", i), v);
      end

      // Reset landing in the second flush cycle aborts the window.
      run_op("pre_rst", tbl[0]);
      in_valid     = 1'b1;
      jump_control = 2'b01;
      rd           = 5'd1;
      imm          = 21'h000010;
      pc           = 32'h0000_0100;
      @(negedge clk);
      in_valid  = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("mid.flush1", 32'(flush), 32'd1);
      @(negedge clk);
      chk("mid.flush2", 32'(flush), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      exp_jc = '0;
      chk("mid.flush_after_rst", 32'(flush),     32'd0);
      chk("mid.res_valid",       32'(res_valid), 32'd0);
      chk("mid.jump_count",      jump_count,     32'd0);
      chk("mid.in_ready",        32'(in_ready),  32'd1);

      in_valid     = 1'b1;
      jump_control = 2'b00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("nopstream.in_ready",  32'(in_ready),  32'd1);
         chk("nopstream.res_valid", 32'(res_valid), 32'd0);
      end
      in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
